// File: rtl/alu_operand_select.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_select
// Brief    : Y86-64 execute-stage ALU operand/function selector with
//            registered outputs, stall hold and bubble insertion.
// Revision : 1.0
// ============================================================================
module alu_operand_select #(
    parameter int WIDTH     = 64,
    parameter int STACK_INC = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             bubble,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_ifun,
    input  logic [WIDTH-1:0] E_valA,
    input  logic [WIDTH-1:0] E_valB,
    input  logic [WIDTH-1:0] E_valC,
    output logic [WIDTH-1:0] aluA,
    output logic [WIDTH-1:0] aluB,
    output logic [1:0]       alufun,
    output logic             set_cc,
    output logic             fun_err
);

    localparam logic [3:0] C_IRRMOVQ = 4'h2;
    localparam logic [3:0] C_IIRMOVQ = 4'h3;
    localparam logic [3:0] C_IRMMOVQ = 4'h4;
    localparam logic [3:0] C_IMRMOVQ = 4'h5;
    localparam logic [3:0] C_IOPQ    = 4'h6;
    localparam logic [3:0] C_ICALL   = 4'h8;
    localparam logic [3:0] C_IRET    = 4'h9;
    localparam logic [3:0] C_IPUSHQ  = 4'hA;
    localparam logic [3:0] C_IPOPQ   = 4'hB;

    localparam logic [1:0] C_ALUADD  = 2'd0;

    // Stack adjustment constants; the negative form is the WIDTH-bit two's complement.
    localparam logic [WIDTH-1:0] C_STACK_POS = WIDTH'(STACK_INC);
    localparam logic [WIDTH-1:0] C_STACK_NEG = -C_STACK_POS;

    logic [WIDTH-1:0] aluA_d, aluA_q;
    logic [WIDTH-1:0] aluB_d, aluB_q;
    logic [1:0]       alufun_d, alufun_q;
    logic             set_cc_d, set_cc_q;
    logic             fun_err_d, fun_err_q;

    always_comb begin
        aluA_d    = '0;
        aluB_d    = '0;
        alufun_d  = C_ALUADD;
        set_cc_d  = 1'b0;
        fun_err_d = 1'b0;

        unique case (E_icode)
            C_IRRMOVQ:            aluA_d = E_valA;
            C_IOPQ:               aluA_d = E_valA;
            C_IIRMOVQ, C_IRMMOVQ,
            C_IMRMOVQ:            aluA_d = E_valC;
            C_ICALL, C_IPUSHQ:    aluA_d = C_STACK_NEG;
            C_IRET, C_IPOPQ:      aluA_d = C_STACK_POS;
            default:              aluA_d = '0;
        endcase

        unique case (E_icode)
            C_IRMMOVQ, C_IMRMOVQ, C_IOPQ, C_ICALL,
            C_IRET, C_IPUSHQ, C_IPOPQ: aluB_d = E_valB;
            default:                   aluB_d = '0;
        endcase

        // An out-of-range OPq function still drives the low bits; status logic reports it.
        if (E_icode == C_IOPQ) begin
            alufun_d  = E_ifun[1:0];
            set_cc_d  = 1'b1;
            fun_err_d = (E_ifun > 4'd3);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aluA_q    <= '0;
            aluB_q    <= '0;
            alufun_q  <= C_ALUADD;
            set_cc_q  <= 1'b0;
            fun_err_q <= 1'b0;
        end else if (bubble) begin
            aluA_q    <= '0;
            aluB_q    <= '0;
            alufun_q  <= C_ALUADD;
            set_cc_q  <= 1'b0;
            fun_err_q <= 1'b0;
        end else if (en) begin
            aluA_q    <= aluA_d;
            aluB_q    <= aluB_d;
            alufun_q  <= alufun_d;
            set_cc_q  <= set_cc_d;
            fun_err_q <= fun_err_d;
        end
    end

    assign aluA    = aluA_q;
    assign aluB    = aluB_q;
    assign alufun  = alufun_q;
    assign set_cc  = set_cc_q;
    assign fun_err = fun_err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_select.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_operand_select
// Brief    : Directed self-checking bench for alu_operand_select.
// Revision : 1.0
// ============================================================================
module tb_alu_operand_select;

    localparam int WIDTH = 64;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             bubble;
    logic [3:0]       E_icode;
    logic [3:0]       E_ifun;
    logic [WIDTH-1:0] E_valA;
    logic [WIDTH-1:0] E_valB;
    logic [WIDTH-1:0] E_valC;
    logic [WIDTH-1:0] aluA;
    logic [WIDTH-1:0] aluB;
    logic [1:0]       alufun;
    logic             set_cc;
    logic             fun_err;

    int checks = 0;
    int errors = 0;

    alu_operand_select #(
        .WIDTH     (WIDTH),
        .STACK_INC (8)
    ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .bubble  (bubble),
        .E_icode (E_icode),
        .E_ifun  (E_ifun),
        .E_valA  (E_valA),
        .E_valB  (E_valB),
        .E_valC  (E_valC),
        .aluA    (aluA),
        .aluB    (aluB),
        .alufun  (alufun),
        .set_cc  (set_cc),
        .fun_err (fun_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [WIDTH-1:0] exp_a,
                       input logic [WIDTH-1:0] exp_b, input logic [1:0] exp_f,
                       input logic exp_cc, input logic exp_fe);
        checks++;
        assert (aluA === exp_a) else begin
            errors++;
            $error("FAIL %s.aluA observed=%h expected=%h", tag, aluA, exp_a);
        end
        checks++;
        assert (aluB === exp_b) else begin
            errors++;
            $error("FAIL %s.aluB observed=%h expected=%h", tag, aluB, exp_b);
        end
        checks++;
        assert (alufun === exp_f) else begin
            errors++;
            $error("FAIL %s.alufun observed=%0d expected=%0d", tag, alufun, exp_f);
        end
        checks++;
        assert (set_cc === exp_cc) else begin
            errors++;
            $error("FAIL %s.set_cc observed=%b expected=%b", tag, set_cc, exp_cc);
        end
        checks++;
        assert (fun_err === exp_fe) else begin
            errors++;
            $error("FAIL %s.fun_err observed=%b expected=%b", tag, fun_err, exp_fe);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        en      = 1'b1;
        bubble  = 1'b0;
        E_icode = 4'h6;
        E_ifun  = 4'h0;
        E_valA  = 64'd5;
        E_valB  = 64'd7;
        E_valC  = 64'd0;

        step();
        step();
        chk("reset_hold", 64'd0, 64'd0, 2'd0, 1'b0, 1'b0);

        rst_n = 1'b1;
        step();
        chk("reset_release", 64'd5, 64'd7, 2'd0, 1'b1, 1'b0);

        E_ifun = 4'h1; E_valA = 64'd3; E_valB = 64'd10;
        step();
        chk("opq_sub", 64'd3, 64'd10, 2'd1, 1'b1, 1'b0);

        E_ifun = 4'h5;
        step();
        chk("opq_badfun", 64'd3, 64'd10, 2'd1, 1'b1, 1'b1);

        E_ifun = 4'h3; E_valA = 64'hDEAD_BEEF_0000_0001; E_valB = 64'h1234;
        step();
        chk("opq_xor", 64'hDEAD_BEEF_0000_0001, 64'h1234, 2'd3, 1'b1, 1'b0);

        E_ifun = 4'h0; E_valA = 64'h55; E_valB = 64'h100; E_valC = 64'h77;
        E_icode = 4'hA;
        step();
        chk("pushq", 64'hFFFF_FFFF_FFFF_FFF8, 64'h100, 2'd0, 1'b0, 1'b0);
        E_icode = 4'hB;
        step();
        chk("popq", 64'd8, 64'h100, 2'd0, 1'b0, 1'b0);
        E_icode = 4'h8;
        step();
        chk("call", 64'hFFFF_FFFF_FFFF_FFF8, 64'h100, 2'd0, 1'b0, 1'b0);
        E_icode = 4'h9;
        step();
        chk("ret", 64'd8, 64'h100, 2'd0, 1'b0, 1'b0);

        E_valA = 64'h11; E_valB = 64'h22; E_valC = 64'h33; E_ifun = 4'h2;
        E_icode = 4'h2;
        step();
        chk("rrmovq", 64'h11, 64'h0, 2'd0, 1'b0, 1'b0);
        E_icode = 4'h3;
        step();
        chk("irmovq", 64'h33, 64'h0, 2'd0, 1'b0, 1'b0);
        E_icode = 4'h4;
        step();
        chk("rmmovq", 64'h33, 64'h22, 2'd0, 1'b0, 1'b0);
        E_icode = 4'h5;
        step();
        chk("mrmovq", 64'h33, 64'h22, 2'd0, 1'b0, 1'b0);
        E_icode = 4'h7;
        step();
        chk("jxx", 64'h0, 64'h0, 2'd0, 1'b0, 1'b0);
        E_icode = 4'hF;
        step();
        chk("invalid_f", 64'h0, 64'h0, 2'd0, 1'b0, 1'b0);
        E_icode = 4'h1;
        step();
        chk("nop", 64'h0, 64'h0, 2'd0, 1'b0, 1'b0);

        E_icode = 4'h6; E_ifun = 4'h0; E_valA = 64'd1; E_valB = 64'd2;
        step();
        chk("stall_load", 64'd1, 64'd2, 2'd0, 1'b1, 1'b0);
        en = 1'b0; E_icode = 4'h3;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_hold", 64'd1, 64'd2, 2'd0, 1'b1, 1'b0);
        end
        bubble = 1'b1;
        step();
        chk("bubble_en0", 64'd0, 64'd0, 2'd0, 1'b0, 1'b0);

        bubble = 1'b0; en = 1'b1; E_icode = 4'h6; E_ifun = 4'h2;
        step();
        chk("reload_and", 64'd1, 64'd2, 2'd2, 1'b1, 1'b0);
        bubble = 1'b1;
        step();
        chk("bubble_en1", 64'd0, 64'd0, 2'd0, 1'b0, 1'b0);

        bubble = 1'b0; E_ifun = 4'h7;
        step();
        chk("pre_async", 64'd1, 64'd2, 2'd3, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", 64'd0, 64'd0, 2'd0, 1'b0, 1'b0);
        step();
        chk("reset_held", 64'd0, 64'd0, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        chk("after_reset", 64'd1, 64'd2, 2'd3, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_operand_select.md
Name: alu_operand_select

Overview:
- Execute-stage ALU operand/function selector for the Y86-64 pipeline.
- Decodes the execute-stage instruction code and function into ALU input A, ALU input B, ALU function code and a condition-code update strobe.
- Sits between the execute pipeline register and the ALU datapath.
- Outputs are registered (one-cycle latency) so the ALU sees stable operands; supports pipeline stall and bubble.

Parameters:
- WIDTH, 64, data word width of valA/valB/valC/aluA/aluB.
- STACK_INC, 8, stack pointer adjustment magnitude for call/push/ret/pop.

Ports:
- clk  in  1  system clock, rising-edge active
- rst_n  in  1  asynchronous active-low reset
- en  in  1  load enable; 0 = hold registered outputs (stall)
- bubble  in  1  load NOP-equivalent (all-zero) outputs
- E_icode  in  4  execute-stage instruction code
- E_ifun  in  4  execute-stage function code
- E_valA  in  WIDTH  operand A from the pipeline register
- E_valB  in  WIDTH  operand B from the pipeline register
- E_valC  in  WIDTH  immediate/displacement
- aluA  out  WIDTH  selected ALU input A (registered)
- aluB  out  WIDTH  selected ALU input B (registered)
- alufun  out  2  ALU op: 0=add, 1=sub, 2=and, 3=xor (registered)
- set_cc  out  1  condition codes update this cycle (registered)
- fun_err  out  1  OPq with ifun > 3 (registered)

Behaviour:
- Icode encoding: 0 HALT, 1 NOP, 2 RRMOVQ/CMOVXX, 3 IRMOVQ, 4 RMMOVQ, 5 MRMOVQ, 6 OPQ, 7 JXX, 8 CALL, 9 RET, A PUSHQ, B POPQ; C–F invalid.
- Next-state aluA selection:
  - E_valA for icode 2 or 6.
  - E_valC for icode 3, 4 or 5.
  - −STACK_INC, two's complement (0xFFFF_FFFF_FFFF_FFF8), for icode 8 or A.
  - +STACK_INC for icode 9 or B.
  - 0 otherwise.
- Next-state aluB selection:
  - E_valB for icode 4, 5, 6, 8, 9, A or B.
  - 0 for icode 2, 3 and all others.
- Next-state alufun:
  - icode 6: E_ifun[1:0].
  - All other icodes: 0 (add).
- Next-state set_cc: 1 iff icode 6.
- Next-state fun_err: 1 iff icode 6 and E_ifun > 3.
  - alufun still takes E_ifun[1:0] in that case; downstream status logic handles the error.
- Register update on rising clk, in priority order:
  - rst_n low: asynchronous clear of all outputs to 0, regardless of clk/en/bubble.
  - bubble=1: all outputs load 0 (aluA=0, aluB=0, alufun=add, set_cc=0, fun_err=0), regardless of en.
  - en=1: load the next-state values.
  - en=0: hold all outputs.
- Latency: inputs sampled at edge N appear on outputs after edge N; no combinational input-to-output path.
- Reset deassertion: first edge with rst_n high obeys the normal update rules.
- Reset mid-operation: outputs clear immediately and stay 0 while rst_n is low.
- Arithmetic: no arithmetic is performed here; constants are sign-extended to WIDTH; operands pass through unmodified.
- Invalid icodes (C–F) and HALT/NOP/JXX: aluA=0, aluB=0, alufun=0, set_cc=0, fun_err=0.

Test Plan:
- Reset: hold rst_n=0, drive icode=6, valA=5, valB=7 with en=1 -> all outputs 0. Release rst_n, one edge -> aluA=5, aluB=7, alufun=ifun[1:0], set_cc=1.
- OPQ sub: icode=6, ifun=1, valA=3, valB=10, en=1 -> after edge: aluA=3, aluB=10, alufun=1, set_cc=1, fun_err=0.
  - Repeat with ifun=5 -> alufun=1, fun_err=1.
- Stack ops, one edge each with valB=0x100:
  - icode=A -> aluA=0xFFFFFFFFFFFFFFF8, aluB=0x100, alufun=0, set_cc=0.
  - icode=B -> aluA=8, aluB=0x100.
  - icode=8 -> aluA=−8.
  - icode=9 -> aluA=8.
- Moves, with valA=0x11, valB=0x22, valC=0x33:
  - icode=2 -> aluA=0x11, aluB=0.
  - icode=3 -> aluA=0x33, aluB=0.
  - icode=4 -> aluA=0x33, aluB=0x22.
  - icode=5 -> aluA=0x33, aluB=0x22.
  - icode=7 -> aluA=0, aluB=0.
  - icode=0xF -> aluA=0, aluB=0.
- Stall/bubble: load OPQ add (valA=1, valB=2), then en=0 with icode=3 for 3 cycles -> outputs hold aluA=1, aluB=2, set_cc=1. Then bubble=1 with en=0 -> all outputs 0.
- Async reset mid-cycle: with outputs non-zero, pull rst_n low between edges -> outputs 0 before the next clk edge.
